// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue and issue-to-execute handshake bundle for issue_scoreboard.
// The slave modport is the issue stage; master is the decode/execute side driving it.
interface issue_scoreboard_if #(
    parameter int NUM_REGS  = 16,
    parameter int PAYLOAD_W = 128
);
    localparam int AW = $clog2(NUM_REGS);

    logic                 dec_valid;
    logic                 dec_ready;
    logic [AW-1:0]        dec_rs1_addr;
    logic                 dec_rs1_used;
    logic [AW-1:0]        dec_rs2_addr;
    logic                 dec_rs2_used;
    logic [AW-1:0]        dec_rd_addr;
    logic                 dec_rd_we;
    logic [AW-1:0]        dec_rd2_addr;
    logic                 dec_rd2_we;
    logic                 dec_is_branch;
    logic                 dec_is_halt;
    logic [PAYLOAD_W-1:0] dec_payload;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [PAYLOAD_W-1:0] iss_payload;

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
               dec_rd_addr, dec_rd_we, dec_rd2_addr, dec_rd2_we, dec_is_branch,
               dec_is_halt, dec_payload, iss_ready,
        input  dec_ready, iss_valid, iss_payload
    );

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs1_used, dec_rs2_addr, dec_rs2_used,
               dec_rd_addr, dec_rd_we, dec_rd2_addr, dec_rd2_we, dec_is_branch,
               dec_is_halt, dec_payload, iss_ready,
        output dec_ready, iss_valid, iss_payload
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue stage: per-register pending-write scoreboard, branch/halt serialisation, one-entry output reg.
// Optional macro SB_WB_BYPASS_EN lets same-cycle writebacks clear hazards before the counters update.
module issue_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int CNT_W     = 2,
    parameter int PAYLOAD_W = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    issue_scoreboard_if.slave           bus,
    input  logic                        wb_rd_we,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd_addr,
    input  logic                        wb_rd2_we,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd2_addr,
    input  logic                        branch_resolved,
    output logic                        halted,
    output logic                        err_underflow,
    output logic [15:0]                 stall_cnt
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;

    typedef logic [CNT_W+1:0] wide_t;
    typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_HALTED} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg  [NUM_REGS];
    logic [CNT_W-1:0]     cnt_next [NUM_REGS];
    logic [CNT_W-1:0]     eff_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0]  under;
    logic                 iss_valid_reg;
    logic [PAYLOAD_W-1:0] iss_payload_reg;
    logic                 err_underflow_reg;
    logic [15:0]          stall_cnt_reg;
    logic                 hazard;
    logic                 issue_ok;
    logic                 accept;

    // Per-register net update: accepted writes add, writeback ports subtract, all in one sum.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            wide_t inc_w, dec_w, sum_w, cur_w;
            assign cur_w = wide_t'(cnt_reg[gi]);
            assign inc_w = wide_t'(accept & bus.dec_rd_we  & (bus.dec_rd_addr  == AW'(gi)))
                         + wide_t'(accept & bus.dec_rd2_we & (bus.dec_rd2_addr == AW'(gi)));
            assign dec_w = wide_t'(wb_rd_we  & (wb_rd_addr  == AW'(gi)))
                         + wide_t'(wb_rd2_we & (wb_rd2_addr == AW'(gi)));
            assign sum_w = cur_w + inc_w;
            assign under[gi]    = (sum_w < dec_w);
            assign cnt_next[gi] = under[gi] ? '0 : CNT_W'(sum_w - dec_w);
`ifdef SB_WB_BYPASS_EN
            assign eff_cnt[gi] = (cur_w < dec_w) ? '0 : CNT_W'(cur_w - dec_w);
`else
            assign eff_cnt[gi] = cnt_reg[gi];
`endif
        end
    endgenerate

    always_comb begin
        hazard = (bus.dec_rs1_used && eff_cnt[bus.dec_rs1_addr] != '0)
              || (bus.dec_rs2_used && eff_cnt[bus.dec_rs2_addr] != '0)
              || (bus.dec_rd_we    && eff_cnt[bus.dec_rd_addr]  == CNT_MAX)
              || (bus.dec_rd2_we   && eff_cnt[bus.dec_rd2_addr] == CNT_MAX)
              || (bus.dec_rd_we && bus.dec_rd2_we && bus.dec_rd_addr == bus.dec_rd2_addr
                  && eff_cnt[bus.dec_rd_addr] >= CNT_MAX_M1);
        issue_ok = (state_reg == S_RUN) && !flush && !hazard && (!iss_valid_reg || bus.iss_ready);
        accept   = bus.dec_valid && issue_ok;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RUN: begin
                if (accept && bus.dec_is_halt)        state_next = S_HALTED;
                else if (accept && bus.dec_is_branch) state_next = S_BR_WAIT;
            end
            S_BR_WAIT: if (branch_resolved || flush) state_next = S_RUN;
            S_HALTED:  state_next = S_HALTED;
            default:   state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= S_RUN;
            iss_valid_reg     <= 1'b0;
            iss_payload_reg   <= '0;
            err_underflow_reg <= 1'b0;
            stall_cnt_reg     <= '0;
            for (int i = 0; i < NUM_REGS; i++) cnt_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (|under) err_underflow_reg <= 1'b1;
            if (bus.dec_valid && !issue_ok && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            // accept is impossible under flush, so flush naturally wins
            if (flush) begin
                iss_valid_reg <= 1'b0;
            end else if (accept) begin
                iss_valid_reg   <= 1'b1;
                iss_payload_reg <= bus.dec_payload;
            end else if (iss_valid_reg && bus.iss_ready) begin
                iss_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.dec_ready   = issue_ok;
    assign bus.iss_valid   = iss_valid_reg;
    assign bus.iss_payload = iss_payload_reg;
    assign halted          = (state_reg == S_HALTED);
    assign err_underflow   = err_underflow_reg;
    assign stall_cnt       = stall_cnt_reg;
endmodule
